wb_retire_buffer: RTL and testbench
===================================

Name: wb_retire_buffer

Overview:
- In-order retire stage directly downstream of the dual-issue writeback stage.
- Captures up to two out-of-order writeback results per cycle, indexed by scoreboard id (sid).
- Retires up to two results per cycle, in sid order, to the integer register file write ports and reports the retire count to the scoreboard.
- Drives the per-slot writeback stall inputs back to the writeback stage.

Parameters:
- SB_W, 3, log2 of the entry count (2**SB_W entries); sid width is SB_W+1, the MSB being the wrap bit.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst0_wb_valid_i  in  1  slot0 writeback valid
- inst0_wb_rd_i  in  5  slot0 destination register
- inst0_wb_value_i  in  64  slot0 result
- inst0_wb_inst_i  in  32  slot0 instruction word
- inst0_wb_sid_i  in  SB_W+1  slot0 sid
- inst1_wb_valid_i, inst1_wb_rd_i, inst1_wb_value_i, inst1_wb_inst_i, inst1_wb_sid_i  in  1/5/64/32/SB_W+1  slot1, same meanings as slot0
- flush_i  in  1  pipeline flush
- flush_sid_i  in  SB_W+1  sid of the oldest surviving instruction after the flush
- stall_inst0_wb_o  out  1  hold slot0 writeback
- stall_inst1_wb_o  out  1  hold slot1 writeback
- rf_we0_o, rf_waddr0_o, rf_wdata0_o  out  1/5/64  regfile write port 0 (older retire)
- rf_we1_o, rf_waddr1_o, rf_wdata1_o  out  1/5/64  regfile write port 1 (younger retire)
- retire_inst0_o, retire_inst1_o  out  32  retired instruction words, for trace
- retire_cnt_o  out  2  instructions retired this cycle (0..2)
- head_sid_o  out  SB_W+1  sid of the next instruction to retire

Behaviour:
- Reset (async, rst_n low):
  - head = 0; all entry done bits = 0.
  - All rf_we*, retire_cnt_o and stall_* = 0.
  - rf_waddr*, rf_wdata*, retire_inst* = 0.
- Entry layout: done, full sid, rd, value, inst.
  - idx = sid[SB_W-1:0].
- Capture:
  - Slot k with valid=1 and stall=0 writes its entry at the clock edge and sets done=1.
- Stall (combinational):
  - stall_instk_wb_o = validk & entry[idxk].done & (entry[idxk].sid != sidk), i.e. the entry is still held by an older unretired instruction.
  - A stalled slot must hold its inputs stable; it is captured in the first cycle the stall drops.
- Retire decision (from registered state):
  - r0 = entry[head].done & entry[head].sid == head.
  - r1 = r0 & the same test on head+1.
  - At the edge:
    - Output registers load the retired entries: port 0 from head, port 1 from head+1.
    - rf_we = retired & rd != 0.
    - retire_cnt_o = r0 + r1.
    - Retired done bits clear.
    - head += retire_cnt, modulo 2**(SB_W+1).
  - Outputs are valid for one cycle; when nothing retires, the we bits and retire_cnt_o return to 0.
- rd == x0: the instruction still retires and counts toward retire_cnt_o, but rf_we stays 0.
- Latency: a result captured at edge N retires at the earliest at edge N+1, so rf_we is visible in cycle N+1.
- Same-index capture and retire in one cycle: the capture's done=1 wins over the retire clear.
- Both slots target the same idx in one cycle: illegal; slot0 is written and slot1 is dropped. Verification flags this with an assertion.
- Wrap-around: the head MSB toggles every 2**SB_W retires. The full-sid compare prevents a stale previous-lap entry from retiring.
- Flush (priority over capture and retire):
  - All done bits clear; head = flush_sid_i.
  - No retire in that cycle; rf_we*, retire_cnt_o = 0.
  - Writebacks presented in that cycle are dropped.
  - stall_* = 0 during flush.
- Reset mid-operation: state returns immediately to reset values; there is no pending-retire recovery.

Test Plan:
- In-order pair: after reset, slot0 {sid0, rd5, 0x11} and slot1 {sid1, rd6, 0x22} in one cycle -> next cycle rf_we0/1 = 1, waddr 5/6, wdata 0x11/0x22, retire_cnt = 2, head_sid = 2.
- Out-of-order: sid1 written in cycle 0 and sid0 in cycle 2 -> no retire in cycles 1-2; in cycle 3 both retire, cnt = 2, port0 carries sid0.
- x0: sid0 with rd = 0 -> retire_cnt = 1, rf_we0 = 0, head advances to 1.
- Wrap and stall:
  - SB_W = 3, sids 0..7 written, sid0 not yet retired, sid8 presented -> stall_inst0_wb_o = 1.
  - After sid0 retires, stall drops and sid8 is captured.
  - sid8 later retires correctly with head MSB = 1.
- Flush: entries sid3..5 done, flush_i with flush_sid_i = 3 -> no retire, done bits cleared, head = 3; a later sid3 write retires normally.
- Async reset asserted mid-retire -> all outputs 0 immediately; head_sid = 0 after release.

Source files
------------

// File: rtl/wb_retire_buffer.sv
// In-order retire buffer behind the dual-issue writeback stage: captures results by sid
// and retires up to two per cycle, in sid order, to the integer register file.
module wb_retire_buffer #(
    parameter int SB_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst0_wb_valid_i,
    input  logic [4:0]      inst0_wb_rd_i,
    input  logic [63:0]     inst0_wb_value_i,
    input  logic [31:0]     inst0_wb_inst_i,
    input  logic [SB_W:0]   inst0_wb_sid_i,
    input  logic            inst1_wb_valid_i,
    input  logic [4:0]      inst1_wb_rd_i,
    input  logic [63:0]     inst1_wb_value_i,
    input  logic [31:0]     inst1_wb_inst_i,
    input  logic [SB_W:0]   inst1_wb_sid_i,
    input  logic            flush_i,
    input  logic [SB_W:0]   flush_sid_i,
    output logic            stall_inst0_wb_o,
    output logic            stall_inst1_wb_o,
    output logic            rf_we0_o,
    output logic [4:0]      rf_waddr0_o,
    output logic [63:0]     rf_wdata0_o,
    output logic            rf_we1_o,
    output logic [4:0]      rf_waddr1_o,
    output logic [63:0]     rf_wdata1_o,
    output logic [31:0]     retire_inst0_o,
    output logic [31:0]     retire_inst1_o,
    output logic [1:0]      retire_cnt_o,
    output logic [SB_W:0]   head_sid_o
);

    localparam int N     = 1 << SB_W;
    localparam int SID_W = SB_W + 1;

    logic [N-1:0]     done_p0;
    logic [N-1:0]     done_d;
    logic [SID_W-1:0] sid_p0   [N];
    logic [4:0]       rd_p0    [N];
    logic [63:0]      value_p0 [N];
    logic [31:0]      inst_p0  [N];
    logic [SID_W-1:0] head_p0;

    logic [SB_W-1:0]  idx0, idx1, hidx0, hidx1;
    logic [SID_W-1:0] head1;
    logic             cap0, cap1, ret0, ret1;
    logic [1:0]       cnt_d;

    // Stage p0: capture / stall decision against registered entry state
    always_comb begin
        idx0  = inst0_wb_sid_i[SB_W-1:0];
        idx1  = inst1_wb_sid_i[SB_W-1:0];
        head1 = head_p0 + SID_W'(1);
        hidx0 = head_p0[SB_W-1:0];
        hidx1 = head1[SB_W-1:0];

        stall_inst0_wb_o = ~flush_i & inst0_wb_valid_i & done_p0[idx0] & (sid_p0[idx0] != inst0_wb_sid_i);
        stall_inst1_wb_o = ~flush_i & inst1_wb_valid_i & done_p0[idx1] & (sid_p0[idx1] != inst1_wb_sid_i);

        // Same-index dual capture is illegal upstream; slot0 wins if it happens anyway.
        cap0 = ~flush_i & inst0_wb_valid_i & ~stall_inst0_wb_o;
        cap1 = ~flush_i & inst1_wb_valid_i & ~stall_inst1_wb_o & ~(cap0 & (idx0 == idx1));

        ret0  = ~flush_i & done_p0[hidx0] & (sid_p0[hidx0] == head_p0);
        ret1  = ret0 & done_p0[hidx1] & (sid_p0[hidx1] == head1);
        cnt_d = {1'b0, ret0} + {1'b0, ret1};
    end

    always_comb begin
        done_d = done_p0;
        if (flush_i) begin
            done_d = '0;
        end else begin
            if (ret0) done_d[hidx0] = 1'b0;
            if (ret1) done_d[hidx1] = 1'b0;
            if (cap0) done_d[idx0]  = 1'b1;
            if (cap1) done_d[idx1]  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_p0 <= '0;
            head_p0 <= '0;
        end else begin
            done_p0 <= done_d;
            head_p0 <= flush_i ? flush_sid_i : head_p0 + SID_W'(cnt_d);
        end
    end

    always_ff @(posedge clk) begin
        if (cap0) begin
            sid_p0[idx0]   <= inst0_wb_sid_i;
            rd_p0[idx0]    <= inst0_wb_rd_i;
            value_p0[idx0] <= inst0_wb_value_i;
            inst_p0[idx0]  <= inst0_wb_inst_i;
        end
        if (cap1) begin
            sid_p0[idx1]   <= inst1_wb_sid_i;
            rd_p0[idx1]    <= inst1_wb_rd_i;
            value_p0[idx1] <= inst1_wb_value_i;
            inst_p0[idx1]  <= inst1_wb_inst_i;
        end
    end

    // Stage p1: registered retire outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we0_o       <= 1'b0;
            rf_we1_o       <= 1'b0;
            retire_cnt_o   <= 2'd0;
            rf_waddr0_o    <= '0;
            rf_wdata0_o    <= '0;
            retire_inst0_o <= '0;
            rf_waddr1_o    <= '0;
            rf_wdata1_o    <= '0;
            retire_inst1_o <= '0;
        end else begin
            rf_we0_o     <= ret0 & (rd_p0[hidx0] != 5'd0);
            rf_we1_o     <= ret1 & (rd_p0[hidx1] != 5'd0);
            retire_cnt_o <= cnt_d;
            if (ret0) begin
                rf_waddr0_o    <= rd_p0[hidx0];
                rf_wdata0_o    <= value_p0[hidx0];
                retire_inst0_o <= inst_p0[hidx0];
            end
            if (ret1) begin
                rf_waddr1_o    <= rd_p0[hidx1];
                rf_wdata1_o    <= value_p0[hidx1];
                retire_inst1_o <= inst_p0[hidx1];
            end
        end
    end

    assign head_sid_o = head_p0;

endmodule

// File: tb/tb_wb_retire_buffer.sv
// Directed scoreboard bench for wb_retire_buffer: expected retires are queued with the
// cycle they must appear in, and a negedge monitor pops and compares them.
module tb_wb_retire_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1;
    logic [4:0]  rd0, rd1;
    logic [63:0] val0, val1;
    logic [31:0] in0, in1;
    logic [3:0]  sid0, sid1;
    logic        flush;
    logic [3:0]  flush_sid;
    logic        stall0, stall1;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [63:0] wd0, wd1;
    logic [31:0] ri0, ri1;
    logic [1:0]  cnt;
    logic [3:0]  head;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [1:0]  cnt;
        logic        we0;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic [31:0] i0;
        logic        we1;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic [31:0] i1;
        logic [3:0]  head;
    } exp_t;

    exp_t q[$];

    wb_retire_buffer #(.SB_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst0_wb_valid_i(v0), .inst0_wb_rd_i(rd0), .inst0_wb_value_i(val0),
        .inst0_wb_inst_i(in0), .inst0_wb_sid_i(sid0),
        .inst1_wb_valid_i(v1), .inst1_wb_rd_i(rd1), .inst1_wb_value_i(val1),
        .inst1_wb_inst_i(in1), .inst1_wb_sid_i(sid1),
        .flush_i(flush), .flush_sid_i(flush_sid),
        .stall_inst0_wb_o(stall0), .stall_inst1_wb_o(stall1),
        .rf_we0_o(we0), .rf_waddr0_o(wa0), .rf_wdata0_o(wd0),
        .rf_we1_o(we1), .rf_waddr1_o(wa1), .rf_wdata1_o(wd1),
        .retire_inst0_o(ri0), .retire_inst1_o(ri1),
        .retire_cnt_o(cnt), .head_sid_o(head)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assert property (@(posedge clk) disable iff (!rst_n)
        !(v0 && v1 && sid0[2:0] == sid1[2:0] && !flush))
        else $error("illegal same-index dual writeback");

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] n,
                        input logic e0, input logic [4:0] a0, input logic [63:0] d0, input logic [31:0] i0,
                        input logic e1, input logic [4:0] a1, input logic [63:0] d1, input logic [31:0] i1,
                        input logic [3:0] h);
        exp_t e;
        e.cyc = c; e.cnt = n;
        e.we0 = e0; e.a0 = a0; e.d0 = d0; e.i0 = i0;
        e.we1 = e1; e.a1 = a1; e.d1 = d1; e.i1 = i1;
        e.head = h;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb0(input logic v, input logic [3:0] s, input logic [4:0] r,
                       input logic [63:0] d, input logic [31:0] i);
        v0 = v; sid0 = s; rd0 = r; val0 = d; in0 = i;
    endtask

    task automatic wb1(input logic v, input logic [3:0] s, input logic [4:0] r,
                       input logic [63:0] d, input logic [31:0] i);
        v1 = v; sid1 = s; rd1 = r; val1 = d; in1 = i;
    endtask

    task automatic idle();
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports a retire.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_retire: got nothing expected cnt %0d at cycle %0d", q[0].cnt, q[0].cyc);
            void'(q.pop_front());
        end
        if (rst_n && cnt != 2'd0) begin
            if (q.size() == 0 || q[0].cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: got cnt %0d expected no retire (cycle %0d)", cnt, cyc);
            end else begin
                e = q.pop_front();
                chk("retire_cnt", cnt, e.cnt);
                chk("rf_we0", we0, e.we0);
                chk("rf_waddr0", wa0, e.a0);
                chk("rf_wdata0", wd0, e.d0);
                chk("retire_inst0", ri0, e.i0);
                chk("rf_we1", we1, e.we1);
                if (e.cnt == 2'd2) begin
                    chk("rf_waddr1", wa1, e.a1);
                    chk("rf_wdata1", wd1, e.d1);
                    chk("retire_inst1", ri1, e.i1);
                end
                chk("head_sid", head, e.head);
            end
        end
    end

    initial begin
        int e0;
        rst_n = 1'b0;
        flush = 1'b0;
        flush_sid = '0;
        wb0(0, 0, 0, 0, 0);
        wb1(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", cnt, 0);
        chk("rst_we0", we0, 0);
        chk("rst_we1", we1, 0);
        chk("rst_head", head, 0);
        chk("rst_stall0", stall0, 0);
        chk("rst_stall1", stall1, 0);
        chk("rst_waddr0", wa0, 0);
        chk("rst_wdata1", wd1, 0);
        chk("rst_inst0", ri0, 0);
        rst_n = 1'b1;
        tick();

        // In-order pair
        wb0(1, 0, 5, 64'h11, 32'h1000);
        wb1(1, 1, 6, 64'h22, 32'h1001);
        push(cyc + 2, 2, 1, 5, 64'h11, 32'h1000, 1, 6, 64'h22, 32'h1001, 2);
        tick(); idle(); tick(); tick();

        // Out of order: younger sid3 first, older sid2 two cycles later
        wb0(1, 3, 7, 64'h33, 32'h1003);
        tick(); idle(); tick();
        wb1(1, 2, 8, 64'h44, 32'h1002);
        push(cyc + 2, 2, 1, 8, 64'h44, 32'h1002, 1, 7, 64'h33, 32'h1003, 4);
        tick(); idle(); tick(); tick();

        // rd == x0 retires without a write
        wb0(1, 4, 0, 64'h55, 32'h1004);
        push(cyc + 2, 1, 0, 0, 64'h55, 32'h1004, 0, 0, 0, 0, 5);
        tick(); idle(); tick(); tick();
        chk("x0_head", head, 5);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rerst_head", head, 0);

        // Wrap and stall: sids 1..7, then sid0, then sid8 collides with unretired sid0
        for (int k = 1; k < 8; k += 2) begin
            wb0(1, 4'(k), 5'(10 + k), 64'(8'hA0 + k), 32'(16'h2000 + k));
            wb1(k < 7, 4'(k + 1), 5'(11 + k), 64'(8'hA1 + k), 32'(16'h2001 + k));
            tick();
        end
        idle();
        wb0(1, 0, 10, 64'hA0, 32'h2000);
        tick();
        e0 = cyc;
        for (int j = 0; j < 4; j++)
            push(e0 + 1 + j, 2,
                 1, 5'(10 + 2 * j), 64'(8'hA0 + 2 * j), 32'(16'h2000 + 2 * j),
                 1, 5'(11 + 2 * j), 64'(8'hA1 + 2 * j), 32'(16'h2001 + 2 * j), 4'(2 * j + 2));
        push(e0 + 5, 1, 1, 2, 64'h800, 32'h2008, 0, 0, 0, 0, 9);
        wb0(1, 8, 2, 64'h800, 32'h2008);
        #1;
        chk("wrap_stall0_on", stall0, 1);
        chk("wrap_stall1_off", stall1, 0);
        tick();
        chk("wrap_stall0_drop", stall0, 0);
        tick(); idle();
        repeat (4) tick();
        chk("wrap_head", head, 9);

        // Flush: sids 11..13 captured behind missing sid9, then flushed to 11
        wb0(1, 11, 20, 64'hB11, 32'h3011);
        wb1(1, 12, 21, 64'hB12, 32'h3012);
        tick();
        wb1(0, 0, 0, 0, 0);
        wb0(1, 13, 22, 64'hB13, 32'h3013);
        tick();
        flush = 1'b1;
        flush_sid = 4'd11;
        wb0(1, 9, 24, 64'hBAD, 32'h3009);
        wb1(1, 3, 25, 64'hBAD, 32'h3003);
        #1;
        chk("flush_stall1", stall1, 0);
        chk("flush_stall0", stall0, 0);
        tick();
        flush = 1'b0;
        idle();
        chk("flush_head", head, 11);
        chk("flush_cnt", cnt, 0);
        tick(); tick();
        wb0(1, 11, 23, 64'hC11, 32'h4011);
        push(cyc + 2, 1, 1, 23, 64'hC11, 32'h4011, 0, 0, 0, 0, 12);
        tick(); idle(); tick(); tick(); tick();
        chk("post_flush_head", head, 12);

        // Async reset while a pair is being retired
        wb0(1, 12, 4, 64'hD12, 32'h5012);
        wb1(1, 13, 5, 64'hD13, 32'h5013);
        push(cyc + 2, 2, 1, 4, 64'hD12, 32'h5012, 1, 5, 64'hD13, 32'h5013, 14);
        tick(); idle(); tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we0", we0, 0);
        chk("arst_we1", we1, 0);
        chk("arst_cnt", cnt, 0);
        chk("arst_wdata0", wd0, 0);
        chk("arst_waddr1", wa1, 0);
        chk("arst_inst1", ri1, 0);
        chk("arst_head", head, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_release_head", head, 0);
        chk("arst_release_cnt", cnt, 0);

        repeat (3) tick();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
